// File: rtl/nibbler_pc_pkg.sv
// Shared types and op decode for the Nibbler program counter / return stack.
// pc_decode resolves the per-cycle priority of the control strobes into a
// single operation; reset is handled by the registers themselves.
package nibbler_pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET,
    PC_ILLEGAL
  } pc_op_t;

  // Priority: (call & ret) > call > ret > load > enable > hold.
  function automatic pc_op_t pc_decode(input logic enable, input logic load,
                                       input logic call, input logic ret);
    if (call && ret) return PC_ILLEGAL;
    if (call)        return PC_CALL;
    if (ret)         return PC_RET;
    if (load)        return PC_LOAD;
    if (enable)      return PC_INC;
    return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_return_stack_if.sv
// Control/status bundle between the decoder FSM (master) and the PC unit
// (slave).
//   master drives: enable, load, call, ret, target, clr_err
//   slave drives : pc, level, empty, full, ovf, udf
interface pc_return_stack_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              enable;
  logic              load;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic              clr_err;
  logic [ADDR_W-1:0] pc;
  logic [LVL_W-1:0]  level;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              udf;

  modport master (
    output enable, load, call, ret, target, clr_err,
    input  pc, level, empty, full, ovf, udf
  );

  modport slave (
    input  enable, load, call, ret, target, clr_err,
    output pc, level, empty, full, ovf, udf
  );
endinterface

// File: rtl/return_stack.sv
// DEPTH x ADDR_W LIFO with a circular write pointer.
//   push/din  : store din on top; when full the oldest entry is overwritten
//   pop       : discard top (ignored when empty)
//   top       : current top entry (valid when !empty)
//   level     : number of valid entries; empty/full decode it
//   overwrite : push while full (an entry is being lost this cycle)
module return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            din,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         empty,
  output logic                         full,
  output logic                         overwrite
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wp_q, wp_d, wp_inc, wp_dec;
  logic [LVL_W-1:0]             level_q, level_d;

  // Explicit wrap so DEPTH need not be a power of two.
  assign wp_inc = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
  assign wp_dec = (wp_q == '0) ? PTR_W'(DEPTH - 1) : wp_q - PTR_W'(1);

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign level     = level_q;
  assign top       = mem_q[wp_dec];
  assign overwrite = push & full;

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    level_d = level_q;
    if (push) begin
      // Writing at wp always lands on the oldest slot once full, so the
      // circular overwrite needs no extra bookkeeping beyond capping level.
      mem_d[wp_q] = din;
      wp_d        = wp_inc;
      if (!full) level_d = level_q + LVL_W'(1);
    end else if (pop && !empty) begin
      wp_d    = wp_dec;
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; it is unobservable while level is zero.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/pc_return_stack.sv
// Nibbler program counter with integrated return-address stack.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus.slave  : enable/load/call/ret/target/clr_err in;
//                pc/level/empty/full/ovf/udf out (all from registers)
module pc_return_stack
  import nibbler_pc_pkg::*;
#(
  parameter int               ADDR_W     = 12,
  parameter int               DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  pc_return_stack_if.slave bus
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  pc_op_t            op;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push, pop, stk_empty, stk_full, stk_ovw;
  logic [LVL_W-1:0]  stk_level;

  assign op     = pc_decode(bus.enable, bus.load, bus.call, bus.ret);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign push   = (op == PC_CALL);
  assign pop    = (op == PC_RET);

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (pc_inc),
    .top       (stk_top),
    .level     (stk_level),
    .empty     (stk_empty),
    .full      (stk_full),
    .overwrite (stk_ovw)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (op)
      PC_INC:  pc_d = pc_inc;
      PC_LOAD: pc_d = bus.target;
      PC_CALL: pc_d = bus.target;
      PC_RET:  if (!stk_empty) pc_d = stk_top;
      default: pc_d = pc_q;
    endcase
    // A fresh error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q & ~bus.clr_err) | stk_ovw;
    udf_d = (udf_q & ~bus.clr_err) | (op == PC_ILLEGAL) |
            ((op == PC_RET) & stk_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.pc    = pc_q;
  assign bus.level = stk_level;
  assign bus.empty = stk_empty;
  assign bus.full  = stk_full;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

endmodule

// File: tb/tb_pc_return_stack.sv
module tb_pc_return_stack;
  import nibbler_pc_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_return_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  pc_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_ADDR(12'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic ld, input logic ca,
                       input logic re, input logic [ADDR_W-1:0] tgt, input logic clr);
    bus.enable = en; bus.load = ld; bus.call = ca; bus.ret = re;
    bus.target = tgt; bus.clr_err = clr;
  endtask

  task automatic chk_st(input string tag, input logic [ADDR_W-1:0] pc,
                        input int lvl, input logic ovf, input logic udf);
    chk({tag, ".pc"},    32'(bus.pc), 32'(pc));
    chk({tag, ".level"}, 32'(bus.level), 32'(lvl));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(lvl == 0));
    chk({tag, ".full"},  32'(bus.full), 32'(lvl == DEPTH));
    chk({tag, ".ovf"},   32'(bus.ovf), 32'(ovf));
    chk({tag, ".udf"},   32'(bus.udf), 32'(udf));
  endtask

  logic [ADDR_W-1:0] call_tgt [5];
  logic [ADDR_W-1:0] ret_pc [4];

  initial begin
    call_tgt = '{12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0, 12'h0E0};
    ret_pc   = '{12'h0D1, 12'h0C1, 12'h0B1, 12'h0A1};

    // Shared decode priority
    chk("dec_call_over_ret_load", 32'(pc_decode(1'b1, 1'b1, 1'b1, 1'b0)), 32'(PC_CALL));
    chk("dec_illegal",            32'(pc_decode(1'b0, 1'b0, 1'b1, 1'b1)), 32'(PC_ILLEGAL));
    chk("dec_load_over_en",       32'(pc_decode(1'b1, 1'b1, 1'b0, 1'b0)), 32'(PC_LOAD));

    // Reset, then increment
    reset = 1'b1;
    drive(0, 0, 0, 0, '0, 0);
    step();
    reset = 1'b0;
    chk_st("reset", 12'h000, 0, 0, 0);
    drive(1, 0, 0, 0, '0, 0);
    step(); chk_st("inc1", 12'h001, 0, 0, 0);
    step(); chk_st("inc2", 12'h002, 0, 0, 0);
    step(); chk_st("inc3", 12'h003, 0, 0, 0);

    // Wrap and load
    drive(0, 1, 0, 0, 12'hFFF, 0); step(); chk_st("load_fff", 12'hFFF, 0, 0, 0);
    drive(1, 0, 0, 0, 12'h000, 0); step(); chk_st("wrap", 12'h000, 0, 0, 0);
    drive(0, 1, 0, 0, 12'h800, 0); step(); chk_st("load_800", 12'h800, 0, 0, 0);

    // Nested call/ret, including ret right after call
    drive(0, 1, 0, 0, 12'h010, 0); step();
    drive(1, 0, 1, 0, 12'h100, 0); step(); chk_st("call1", 12'h100, 1, 0, 0);
    drive(1, 1, 1, 0, 12'h200, 0); step(); chk_st("call2", 12'h200, 2, 0, 0);
    drive(1, 1, 0, 1, 12'h7FF, 0); step(); chk_st("ret1", 12'h101, 1, 0, 0);
    drive(0, 0, 0, 1, 12'h000, 0); step(); chk_st("ret2", 12'h011, 0, 0, 0);

    // Overflow by five calls, four rets, then underflow
    drive(0, 1, 0, 0, 12'h000, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, call_tgt[i], 0); step();
    end
    chk_st("ovf", 12'h0E0, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 12'h000, 0); step();
      chk_st($sformatf("ovf_ret%0d", i), ret_pc[i], 3 - i, 1, 0);
    end
    step(); chk_st("udf_ret", 12'h0A1, 0, 1, 1);
    drive(0, 0, 0, 0, 12'h000, 1); step(); chk_st("clr1", 12'h0A1, 0, 0, 0);

    // Illegal call & ret
    drive(0, 1, 0, 0, 12'h01F, 0); step();
    drive(0, 0, 1, 0, 12'h020, 0); step(); chk_st("pre_ill", 12'h020, 1, 0, 0);
    drive(1, 0, 1, 1, 12'h300, 0); step(); chk_st("illegal", 12'h020, 1, 0, 1);
    drive(0, 0, 0, 0, 12'h000, 1); step(); chk_st("clr2", 12'h020, 1, 0, 0);

    // Reset mid-sequence together with call
    drive(0, 0, 1, 0, 12'h400, 0); step();
    drive(0, 0, 1, 0, 12'h500, 0); step(); chk_st("lvl3", 12'h500, 3, 0, 0);
    reset = 1'b1;
    drive(0, 0, 1, 0, 12'h600, 0); step();
    reset = 1'b0;
    chk_st("rst_call", 12'h000, 0, 0, 0);
    drive(0, 0, 0, 1, 12'h000, 0); step(); chk_st("rst_udf", 12'h000, 0, 0, 1);

    // New error in the same cycle as clr_err keeps the flag
    drive(0, 0, 0, 1, 12'h000, 1); step(); chk_st("clr_vs_err", 12'h000, 0, 0, 1);
    drive(0, 0, 0, 0, 12'h000, 1); step(); chk_st("clr3", 12'h000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Parametrised program counter with an integrated hardware return-address stack for the Nibbler core. It provides sequential fetch (increment), absolute jump (load), subroutine call (push return address and jump) and return (pop and jump), with occupancy status and sticky overflow/underflow error flags. It sits between the decoder/control FSM and the program ROM address input, and drives the fetch address directly.

## Interface
Parameters:
- ADDR_W, 12, PC and return-address width
- DEPTH, 4, return-stack entries (≥2)
- RESET_ADDR, 0, PC value after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- enable  in  1  allow increment when no other operation is active
- load  in  1  jump: pc <= target
- call  in  1  push pc+1, pc <= target
- ret  in  1  pc <= popped address
- target  in  ADDR_W  jump/call destination
- clr_err  in  1  clear sticky error flags
- pc  out  ADDR_W  current fetch address (registered)
- level  out  $clog2(DEPTH+1)  number of valid stack entries
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- ovf  out  1  sticky: call while full
- udf  out  1  sticky: ret while empty, or call and ret in the same cycle

## Operation
- Per-cycle priority: reset > (call & ret) > call > ret > load > enable > hold.
- reset: pc=RESET_ADDR, level=0, empty=1, full=0, ovf=0, udf=0. Stack RAM is not cleared; its contents are never observable while empty.
- call & ret together: illegal. pc holds, stack unchanged, udf<=1.
- call: push (pc+1) mod 2^ADDR_W, pc<=target, level+1.
- call while full: circular overwrite. The oldest entry is discarded, the new entry is pushed, level stays DEPTH, and ovf<=1. Subsequent DEPTH returns yield the newest DEPTH addresses in LIFO order.
- ret: pc<=top entry, level-1.
- ret while empty: pc holds, level stays 0, udf<=1.
- load: pc<=target. The stack is untouched. load is ignored when call or ret is active, because call already uses target.
- enable: pc<=(pc+1) mod 2^ADDR_W. Wraps all-ones to 0 with no flag.
- call, ret and load act regardless of enable.
- clr_err: clears ovf/udf. A new error raised in the same cycle wins, so the flag remains 1.
- Arithmetic is unsigned modulo 2^ADDR_W. No carry-out.

## Timing
- All outputs are registered. Every operation takes effect at the clock edge on which it is sampled, and the result is visible the following cycle (1-cycle latency).
- Back-to-back call/ret on consecutive cycles is supported at full rate, with no bubbles.
- ret in the cycle immediately after call returns the address just pushed.
- Status outputs (level, empty, full) update on the same edge as pc.
- Reset asserted mid-sequence discards the whole stack on that edge. ret on the next cycle is an underflow.

## Structure
- Package nibbler_pc_pkg:
  - enum pc_op_t {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_ILLEGAL}
  - function pc_decode(enable, load, call, ret) implementing the priority above. The decoder and the bench share it.
- Sub-module return_stack: DEPTH×ADDR_W LIFO with circular write pointer, push/pop, level, full/empty, and an overwrite-on-full indication.
- The top level holds the pc register, the increment adder, the op mux and the sticky flags.

## Test plan
All scenarios use ADDR_W=12, DEPTH=4.
- Reset then enable for 3 cycles → pc 0x000, 0x001, 0x002, 0x003; empty=1, level=0.
- pc=0xFFF, enable → pc=0x000, no flags. load target=0x800 → pc=0x800 and level unchanged.
- From pc=0x010: call 0x100, call 0x200, ret, ret → pc 0x100, 0x200, 0x101, 0x011; level 1, 2, 1, 0.
- From pc=0x000: 5 consecutive calls to 0x0A0, 0x0B0, 0x0C0, 0x0D0, 0x0E0 → ovf=1, level=4. Then 4 rets → pc 0x0D1, 0x0C1, 0x0B1, 0x0A1. A 5th ret → udf=1 and pc holds at 0x0A1.
- call & ret in the same cycle at pc=0x020, level=1 → pc=0x020, level=1, udf=1. clr_err → udf=0 next cycle.
- level=3, then reset asserted together with call → pc=RESET_ADDR, level=0, flags 0. ret next cycle → udf=1.
